vga_timing_gen: RTL

Parametrised VGA/raster timing generator: it produces horizontal and vertical sync, data-enable, pixel coordinates and frame/line markers for any mode described by active, front-porch, sync and back-porch lengths. It supersedes the fixed-mode sync generator. It adds programmable sync polarity, an integer pixel-clock divider, a run/hold enable, asynchronous reset and a frame counter. It sits between the board clock and the pixel-pipeline / VGA output pins. Its x/y drive framebuffer address generation.

---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the pixel pipeline.
interface vga_timing_if #(
   parameter int unsigned XW = 11,
   parameter int unsigned YW = 10
);
   logic          en;
   logic          pix_en;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          line_start;
   logic          frame_start;
   logic [15:0]   frame_cnt;

   modport master (
      input  en,
      output pix_en, hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
   );

   modport slave (
      output en,
      input  pix_en, hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: divided pixel tick, x/y counters and
// registered sync/de/marker outputs decoded from the next raster position.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_PRIME | no frame start seen since reset; first (0,0) is frame 0
// ST_COUNT | every later wrap to (0,0) increments frame_cnt
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned XW       = 11,
   parameter int unsigned YW       = 10
) (
   input logic         clk,
   input logic         rst,
   vga_timing_if.master vif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_HS_ON  = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] X_HS_OFF = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_VS_ON  = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] Y_VS_OFF = YW'(V_ACTIVE + V_FP + V_SYNC);

   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1
       || CLK_DIV < 1) begin : g_badMode
      $error("vga_timing_gen: porch, sync and divider lengths must all be >= 1");
   end
   if (((H_TOTAL - 1) >> XW) != 0 || ((V_TOTAL - 1) >> YW) != 0) begin : g_badWidth
      $error("vga_timing_gen: XW/YW too narrow for the configured totals");
   end

   typedef enum logic {ST_PRIME, ST_COUNT} frameState_t;

   frameState_t   frameState, frameStateNext;
   logic          cntInc;

   logic [DW-1:0] divCnt, divNext;
   logic [XW-1:0] xCnt, xNext;
   logic [YW-1:0] yCnt, yNext;
   logic          pixTick, xWrap, yWrap, frameWrap;
   logic          deNext, hsNext, vsNext, lsNext, fsNext;
   logic          deReg, hsReg, vsReg, lsReg, fsReg;
   logic [15:0]   frameCnt;

   always_comb begin
      pixTick = vif.en && (divCnt == DIV_LAST);
      divNext = divCnt;
      if (vif.en) begin
         divNext = (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
      end

      xWrap = (xCnt == X_LAST);
      yWrap = (yCnt == Y_LAST);
      xNext = xCnt;
      yNext = yCnt;
      if (pixTick) begin
         xNext = xWrap ? '0 : xCnt + 1'b1;
         if (xWrap) begin
            yNext = yWrap ? '0 : yCnt + 1'b1;
         end
      end
      frameWrap = pixTick && xWrap && yWrap;
   end

   // Decode from the next position so the registered outputs line up with x/y.
   always_comb begin
      deNext = (xNext < X_ACT) && (yNext < Y_ACT);
      hsNext = ((xNext >= X_HS_ON) && (xNext < X_HS_OFF)) ? HS_POL : ~HS_POL;
      vsNext = ((yNext >= Y_VS_ON) && (yNext < Y_VS_OFF)) ? VS_POL : ~VS_POL;
      lsNext = (xNext == '0);
      fsNext = lsNext && (yNext == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frameState <= ST_PRIME;
      end else begin
         frameState <= frameStateNext;
      end
   end

   always_comb begin
      frameStateNext = frameState;
      cntInc         = 1'b0;
      case (frameState)
         ST_PRIME: begin
            if (frameWrap) frameStateNext = ST_COUNT;
         end
         ST_COUNT: begin
            cntInc = frameWrap;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divCnt   <= '0;
         xCnt     <= X_LAST;
         yCnt     <= Y_LAST;
         deReg    <= 1'b0;
         hsReg    <= ~HS_POL;
         vsReg    <= ~VS_POL;
         lsReg    <= 1'b0;
         fsReg    <= 1'b0;
         frameCnt <= '0;
      end else begin
         divCnt <= divNext;
         if (pixTick) begin
            xCnt  <= xNext;
            yCnt  <= yNext;
            deReg <= deNext;
            hsReg <= hsNext;
            vsReg <= vsNext;
            lsReg <= lsNext;
            fsReg <= fsNext;
            if (cntInc) frameCnt <= frameCnt + 16'd1;
         end
      end
   end

   assign vif.pix_en      = pixTick;
   assign vif.hsync       = hsReg;
   assign vif.vsync       = vsReg;
   assign vif.de          = deReg;
   assign vif.x           = xCnt;
   assign vif.y           = yCnt;
   assign vif.line_start  = lsReg;
   assign vif.frame_start = fsReg;
   assign vif.frame_cnt   = frameCnt;

endmodule
